serial_alu_ctrl: RTL

- Bit-serial ALU controller. Sequences one shared 1-bit gate-level slice (full adder plus logic ops, built from nand2/not1/and2/or2/xor2) across WIDTH-bit operands, LSB first, one bit per clock.
- Start/ready request handshake; result/valid response held until the next accepted request.
- Trades a WIDTH-bit gate datapath for one slice plus a counter. Sits between the CPU's control unit and the shared gate slice.

---
 rtl/serial_alu_pkg.sv | 17 +
 rtl/and2.sv | 8 +
 rtl/nand2.sv | 8 +
 rtl/not1.sv | 7 +
 rtl/or2.sv | 8 +
 rtl/serial_alu_slice.sv | 27 ++
 rtl/xor2.sv | 8 +
 rtl/serial_alu_ctrl.sv | 138 +++++++++++++
 8 files changed

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared op and FSM state encodings for the bit-serial ALU.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/and2.sv
// and2: 2-input AND gate.
module and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/nand2.sv
// nand2: 2-input NAND gate.
module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// File: rtl/not1.sv
// not1: inverter.
module not1 (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// File: rtl/or2.sv
// or2: 2-input OR gate.
module or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/serial_alu_slice.sv
// serial_alu_slice: one gate-level ALU bit (full adder plus AND/XOR), selected by op.
module serial_alu_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       y,
    output logic       cout
);
    logic t, g, s, p, c, n0, n1, m0, m1, lg, k0, k1;

    xor2 u_t  (.a(a),   .b(b),   .y(t));
    and2 u_g  (.a(a),   .b(b),   .y(g));
    xor2 u_s  (.a(t),   .b(cin), .y(s));
    and2 u_p  (.a(t),   .b(cin), .y(p));
    or2  u_c  (.a(g),   .b(p),   .y(c));
    not1 u_n0 (.a(op[0]), .y(n0));
    not1 u_n1 (.a(op[1]), .y(n1));
    // Muxes as NAND-NAND: op[0] picks XOR over AND, op[1] picks logic over sum
    nand2 u_m0 (.a(n0),    .b(g),  .y(m0));
    nand2 u_m1 (.a(op[0]), .b(t),  .y(m1));
    nand2 u_lg (.a(m0),    .b(m1), .y(lg));
    nand2 u_k0 (.a(n1),    .b(s),  .y(k0));
    nand2 u_k1 (.a(op[1]), .b(lg), .y(k1));
    nand2 u_y  (.a(k0),    .b(k1), .y(y));
    and2  u_co (.a(n1),    .b(c),  .y(cout));
endmodule

// File: rtl/xor2.sv
// xor2: 2-input XOR gate.
module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: sequences one ALU slice over WIDTH bits, LSB first, one bit per clock.
// Optional SERIAL_ALU_FLAGS_EN adds registered zero (zr) and negative (ng) flags.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             zr,
    output logic             ng
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, valid_q, valid_d;
    logic [WIDTH:0]   res_sh;
    logic             s_y, s_cout, last;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             zacc_q, zacc_d, zr_q, zr_d, ng_q, ng_d;
`endif

    serial_alu_slice u_slice (
        .a    (a_q[0]),
        .b    (b_q[0] ^ (op_q == OP_SUB)),
        .cin  (carry_q),
        .op   (op_q),
        .y    (s_y),
        .cout (s_cout)
    );

    assign res_sh = {s_y, result_q};
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        valid_d  = valid_q;
`ifdef SERIAL_ALU_FLAGS_EN
        zacc_d   = zacc_q;
        zr_d     = zr_q;
        ng_d     = ng_q;
`endif
        if (state_q == ST_RUN) begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            result_d = res_sh[WIDTH:1];
            carry_d  = s_cout;
            cnt_d    = cnt_q + CNT_W'(1);
`ifdef SERIAL_ALU_FLAGS_EN
            zacc_d   = zacc_q | s_y;
`endif
            if (last) begin
                state_d = ST_DONE;
                valid_d = 1'b1;
                cout_d  = s_cout;
`ifdef SERIAL_ALU_FLAGS_EN
                zr_d    = ~(zacc_q | s_y);
                ng_d    = s_y;
`endif
            end
        end else if (start) begin
            state_d = ST_RUN;
            op_d    = op_e'(op);
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
            valid_d = 1'b0;
            carry_d = (op == OP_SUB);
`ifdef SERIAL_ALU_FLAGS_EN
            zacc_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            zacc_q   <= 1'b0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            valid_q  <= valid_d;
`ifdef SERIAL_ALU_FLAGS_EN
            zacc_q   <= zacc_d;
            zr_q     <= zr_d;
            ng_q     <= ng_d;
`endif
        end
    end

    assign ready  = (state_q != ST_RUN);
    assign valid  = valid_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
    assign zr     = zr_q;
    assign ng     = ng_q;
`endif
endmodule
